cache_line_fill: RTL and testbench
==================================

// Module: cache_line_fill
// PURPOSE
//  Upstream fill stage for the 1024x32 byte-enable cache data RAM (write port b).
//  Takes a wrapped, critical-beat-first SDRAM read burst of 16-bit beats and issues
//  one half-word write per beat (data replicated, byte-enables select the half).
//  Forwards the critical beat to the CPU early and reports completion, abort or timeout.
// PARAMETERS
//  AW       10   RAM address width in 32-bit words
//  LBEATS   3    log2(beats per line); line = 2**LBEATS beats of 16 bits
//  TIMEOUT  255  max idle cycles between accepted beats before fill_err (8-bit counter)
// PORTS
//  clock        in   1          system clock, all logic on rising edge
//  reset_n      in   1          asynchronous active-low reset
//  fill_req     in   1          start pulse; sampled only in IDLE
//  fill_line    in   AW-LBEATS+1  line index, one line = 2**(LBEATS-1) RAM words
//  fill_beat    in   LBEATS     critical beat offset inside line (wrap start)
//  fill_abort   in   1          cancel current fill
//  fill_busy    out  1          high from accepted fill_req until the fill ends
//  fill_done    out  1          one-cycle pulse, final beat written
//  fill_err     out  1          one-cycle pulse, timeout expired
//  sd_dv        in   1          SDRAM beat valid
//  sd_data      in   16         SDRAM beat data
//  crit_valid   out  1          one-cycle pulse, critical beat on crit_data
//  crit_data    out  16         critical beat, held until next fill
//  ram_wren     out  1          RAM port b write enable
//  ram_addr     out  AW         RAM port b word address
//  ram_byteena  out  4          RAM port b byte enables
//  ram_data     out  32         RAM port b write data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-fill discards the line.
//  States: IDLE -> WAIT (fill_req) -> FILL (first sd_dv) -> IDLE (last beat/abort/timeout).
//  IDLE: latch fill_line, fill_beat into beat pointer bp; busy<=1 next cycle.
//   sd_dv in IDLE is ignored.
//  WAIT/FILL, each sd_dv: write issued next cycle (1-cycle registered latency):
//   ram_addr = {line, bp[LBEATS-1:1]}, ram_data = {sd_data, sd_data},
//   ram_byteena = bp[0] ? 4'b1100 : 4'b0011, ram_wren = 1 for one cycle.
//   bp <= bp+1 modulo 2**LBEATS (wrap inside line, line index never changes).
//   beat counter cnt increments; fill ends when cnt reaches 2**LBEATS.
//  First beat (WAIT->FILL): crit_data <= sd_data, crit_valid pulses in the same
//   cycle as its RAM write.
//  fill_done pulses together with the last ram_wren; busy drops the same cycle.
//   A new fill_req is accepted the cycle after.
//  Timeout: idle counter clears on each sd_dv and increments otherwise in WAIT/FILL.
//   When it reaches TIMEOUT: fill_err pulses, busy drops, state returns to IDLE.
//   Beats already written stay in the RAM. The caller must invalidate the tag.
//  fill_abort in WAIT/FILL: no further writes; a write already registered still
//   completes. Returns to IDLE next cycle. No done or err pulse.
//   Abort has priority over a simultaneous sd_dv.
//   Abort takes precedence over a timeout in the same cycle.
//  fill_req while busy: ignored. Extra sd_dv after the last beat: ignored.
//  ram_wren never asserts outside an accepted beat.
//  Only one ram_wren is issued per cycle, so back-to-back sd_dv every cycle is supported.
// TESTING
//  1 line 0x05, beat 0, 8 consecutive sd_dv 0x1000..0x1007:
//    writes addr 0x14..0x17, byteena 0011/1100 alternating.
//    crit_data = 0x1000. done after 8th write.
//  2 line 0x7F, beat 5, data 0xA0..0xA7:
//    bp order 5,6,7,0..4. First write addr 0x1FE, byteena 1100.
//    Last write addr 0x1FE, byteena 0011. crit_data = 0x00A0.
//  3 sd_dv gaps of 0..3 cycles, and sd_dv before fill_req:
//    early beat ignored. Exactly 8 writes, done once.
//  4 TIMEOUT=4, 3 beats then silence:
//    fill_err on the 4th idle cycle. 3 writes only. busy low afterwards.
//  5 fill_abort together with the 4th sd_dv:
//    no 4th write. No done or err. A new fill_req next cycle is accepted.
//  6 reset_n low during beat 2, then released:
//    all outputs 0 asynchronously. Next fill runs normally.

Source files
------------

// File: rtl/cache_line_fill.sv
// Line-fill stage: turns a wrapped, critical-beat-first burst of 16-bit SDRAM beats
// into half-word writes on the cache data RAM port and forwards the critical beat.
module cache_line_fill #(
    parameter int AW      = 10,
    parameter int LBEATS  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                fill_req,
    input  logic [AW-LBEATS:0]  fill_line,
    input  logic [LBEATS-1:0]   fill_beat,
    input  logic                fill_abort,
    output logic                fill_busy,
    output logic                fill_done,
    output logic                fill_err,
    input  logic                sd_dv,
    input  logic [15:0]         sd_data,
    output logic                crit_valid,
    output logic [15:0]         crit_data,
    output logic                ram_wren,
    output logic [AW-1:0]       ram_addr,
    output logic [3:0]          ram_byteena,
    output logic [31:0]         ram_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;

    localparam logic [LBEATS-1:0] LAST_BEAT   = '1;
    localparam logic [7:0]        TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [AW-LBEATS:0]  line;
    logic [LBEATS-1:0]   bp;
    logic [LBEATS-1:0]   cnt;
    logic [7:0]          idle_cnt;
    logic [7:0]          idle_next;
    logic                start;
    logic                take_beat;
    logic                last_beat;
    logic                time_out;

    assign idle_next = idle_cnt + 8'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // sd_dv carries no back-pressure: every beat seen in WAIT/FILL is consumed.
    // Abort outranks a simultaneous beat, and a beat or abort outranks the timeout.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        take_beat  = 1'b0;
        last_beat  = 1'b0;
        time_out   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill_req) begin
                    start      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT, S_FILL: begin
                if (fill_abort) begin
                    state_next = S_IDLE;
                end else if (sd_dv) begin
                    take_beat = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        last_beat  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FILL;
                    end
                end else if (idle_next == TIMEOUT_CNT) begin
                    time_out   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line        <= '0;
            bp          <= '0;
            cnt         <= '0;
            idle_cnt    <= '0;
            fill_busy   <= 1'b0;
            fill_done   <= 1'b0;
            fill_err    <= 1'b0;
            crit_valid  <= 1'b0;
            crit_data   <= '0;
            ram_wren    <= 1'b0;
            ram_addr    <= '0;
            ram_byteena <= '0;
            ram_data    <= '0;
        end else begin
            ram_wren   <= take_beat;
            crit_valid <= take_beat && (state == S_WAIT);
            fill_done  <= last_beat;
            fill_err   <= time_out;

            if (start) begin
                line      <= fill_line;
                bp        <= fill_beat;
                cnt       <= '0;
                idle_cnt  <= '0;
                fill_busy <= 1'b1;
            end

            if (take_beat) begin
                // Two beats share one 32-bit word; bp[0] picks the half.
                ram_addr    <= {line, bp[LBEATS-1:1]};
                ram_byteena <= bp[0] ? 4'b1100 : 4'b0011;
                ram_data    <= {sd_data, sd_data};
                bp          <= bp + 1'b1;
                cnt         <= cnt + 1'b1;
                idle_cnt    <= '0;
                if (state == S_WAIT) crit_data <= sd_data;
            end else if (state != S_IDLE) begin
                idle_cnt <= idle_next;
            end

            if (state != S_IDLE && state_next == S_IDLE) fill_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: wrapped fills, gaps, timeout, abort and reset.
module tb_cache_line_fill;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fill_req;
    logic [7:0]  fill_line;
    logic [2:0]  fill_beat;
    logic        fill_abort;
    logic        fill_busy;
    logic        fill_done;
    logic        fill_err;
    logic        sd_dv;
    logic [15:0] sd_data;
    logic        crit_valid;
    logic [15:0] crit_data;
    logic        ram_wren;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_data;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int exp_done = 0;
    int exp_err = 0;

    // {done, crit, addr, byteena, data}
    logic [47:0] exp_q[$];

    cache_line_fill #(.AW(10), .LBEATS(3), .TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .fill_req(fill_req), .fill_line(fill_line), .fill_beat(fill_beat),
        .fill_abort(fill_abort), .fill_busy(fill_busy), .fill_done(fill_done),
        .fill_err(fill_err), .sd_dv(sd_dv), .sd_data(sd_data),
        .crit_valid(crit_valid), .crit_data(crit_data), .ram_wren(ram_wren),
        .ram_addr(ram_addr), .ram_byteena(ram_byteena), .ram_data(ram_data)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_fill(input logic [7:0] line, input logic [2:0] beat);
        fill_req  = 1'b1;
        fill_line = line;
        fill_beat = beat;
        step();
        fill_req  = 1'b0;
    endtask

    task automatic send(input logic [15:0] data, input int gap);
        sd_dv   = 1'b1;
        sd_data = data;
        step();
        sd_dv   = 1'b0;
        repeat (gap) step();
    endtask

    task automatic push(input logic [7:0] line, input logic [2:0] bp, input logic [15:0] data,
                        input logic crit, input logic done);
        logic [3:0] be;
        be = bp[0] ? 4'b1100 : 4'b0011;
        exp_q.push_back({done, crit, line, bp[2:1], be, data, data});
    endtask

    // scoreboard: every RAM write must match the head of exp_q
    always @(negedge clock) begin
        if (reset_n) begin
            if (fill_done) done_seen++;
            if (fill_err)  err_seen++;
            if (ram_wren) begin
                chk("write_expected", 72'(exp_q.size() != 0), 72'd1);
                if (exp_q.size() != 0)
                    chk("ram_write", 72'({fill_done, crit_valid, ram_addr, ram_byteena, ram_data}),
                        72'(exp_q.pop_front()));
            end else begin
                chk("strobe_without_write", 72'({fill_done, crit_valid}), 72'd0);
            end
        end
    end

    initial begin
        logic [2:0] bp;
        reset_n    = 1'b0;
        fill_req   = 1'b0;
        fill_line  = '0;
        fill_beat  = '0;
        fill_abort = 1'b0;
        sd_dv      = 1'b0;
        sd_data    = '0;
        repeat (3) step();
        chk("reset_outputs", 72'({fill_busy, fill_done, fill_err, crit_valid, crit_data,
                                  ram_wren, ram_addr, ram_byteena, ram_data}), 72'd0);
        reset_n = 1'b1;
        step();

        // 1: line 0x05, beat 0, back-to-back beats
        start_fill(8'h05, 3'd0);
        chk("t1_busy", 72'(fill_busy), 72'd1);
        for (int i = 0; i < 8; i++) begin
            push(8'h05, 3'(i), 16'(16'h1000 + i), i == 0, i == 7);
            send(16'(16'h1000 + i), 0);
        end
        chk("t1_last_addr", 72'({ram_addr, ram_byteena}), 72'({10'h017, 4'b1100}));
        chk("t1_done_busy", 72'({fill_done, fill_busy}), 72'({1'b1, 1'b0}));
        step();
        exp_done++;
        chk("t1_crit_data", 72'(crit_data), 72'h1000);
        chk("t1_done_count", 72'(done_seen), 72'(exp_done));
        chk("t1_queue_empty", 72'(exp_q.size()), 72'd0);

        // 2: line 0x7F, critical beat 5, wraps inside the line
        start_fill(8'h7F, 3'd5);
        for (int i = 0; i < 8; i++) begin
            bp = 3'(5 + i);
            push(8'h7F, bp, 16'(16'h00A0 + i), i == 0, i == 7);
            send(16'(16'h00A0 + i), 0);
            if (i == 0)
                chk("t2_first_write", 72'({crit_valid, ram_addr, ram_byteena}),
                    72'({1'b1, 10'h1FE, 4'b1100}));
            if (i == 7)
                chk("t2_last_write", 72'({fill_done, ram_addr, ram_byteena}),
                    72'({1'b1, 10'h1FE, 4'b0011}));
        end
        step();
        exp_done++;
        chk("t2_crit_data", 72'(crit_data), 72'h00A0);
        chk("t2_done_count", 72'(done_seen), 72'(exp_done));

        // 3: beat in IDLE, gaps 0..3, fill_req while busy, extra beat after the last
        sd_dv   = 1'b1;
        sd_data = 16'hDEAD;
        step();
        sd_dv   = 1'b0;
        chk("t3_idle_beat_ignored", 72'({ram_wren, fill_busy}), 72'd0);
        start_fill(8'h21, 3'd3);
        for (int i = 0; i < 8; i++) begin
            bp = 3'(3 + i);
            push(8'h21, bp, 16'(16'h2100 + i), i == 0, i == 7);
            sd_dv   = 1'b1;
            sd_data = 16'(16'h2100 + i);
            step();
            sd_dv   = 1'b0;
            if (i == 1) begin
                fill_req  = 1'b1;
                fill_line = 8'h33;
                fill_beat = 3'd0;
            end
            repeat (i % 4) step();
            fill_req = 1'b0;
        end
        send(16'hBEEF, 1);
        exp_done++;
        chk("t3_done_count", 72'(done_seen), 72'(exp_done));
        chk("t3_crit_data", 72'(crit_data), 72'h2100);
        chk("t3_busy_low", 72'(fill_busy), 72'd0);
        chk("t3_queue_empty", 72'(exp_q.size()), 72'd0);

        // 4: three beats then silence until timeout
        start_fill(8'h10, 3'd6);
        for (int i = 0; i < 3; i++) begin
            bp = 3'(6 + i);
            push(8'h10, bp, 16'(16'h4400 + i), i == 0, 1'b0);
            send(16'(16'h4400 + i), 0);
        end
        repeat (3) step();
        chk("t4_no_err_yet", 72'({fill_err, fill_busy}), 72'({1'b0, 1'b1}));
        step();
        chk("t4_err_pulse", 72'({fill_err, fill_busy}), 72'({1'b1, 1'b0}));
        step();
        exp_err++;
        chk("t4_err_single", 72'(fill_err), 72'd0);
        chk("t4_err_count", 72'(err_seen), 72'(exp_err));
        chk("t4_done_count", 72'(done_seen), 72'(exp_done));
        chk("t4_queue_empty", 72'(exp_q.size()), 72'd0);

        // 5: abort together with the 4th beat, then an immediate new fill
        start_fill(8'h02, 3'd0);
        for (int i = 0; i < 3; i++) begin
            push(8'h02, 3'(i), 16'(16'h5500 + i), i == 0, 1'b0);
            send(16'(16'h5500 + i), 0);
        end
        sd_dv      = 1'b1;
        sd_data    = 16'h5555;
        fill_abort = 1'b1;
        step();
        sd_dv      = 1'b0;
        fill_abort = 1'b0;
        chk("t5_abort_busy_low", 72'(fill_busy), 72'd0);
        start_fill(8'h03, 3'd2);
        chk("t5_refill_busy", 72'(fill_busy), 72'd1);
        for (int i = 0; i < 8; i++) begin
            bp = 3'(2 + i);
            push(8'h03, bp, 16'(16'h3300 + i), i == 0, i == 7);
            send(16'(16'h3300 + i), 0);
        end
        step();
        exp_done++;
        chk("t5_crit_data", 72'(crit_data), 72'h3300);
        chk("t5_done_count", 72'(done_seen), 72'(exp_done));
        chk("t5_err_count", 72'(err_seen), 72'(exp_err));

        // 6: asynchronous reset while beat 2 is on the bus
        start_fill(8'h40, 3'd1);
        push(8'h40, 3'd1, 16'h6600, 1'b1, 1'b0);
        send(16'h6600, 1);
        push(8'h40, 3'd2, 16'h6601, 1'b0, 1'b0);
        send(16'h6601, 1);
        sd_dv   = 1'b1;
        sd_data = 16'h6602;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", 72'({fill_busy, fill_done, fill_err, crit_valid, crit_data,
                                   ram_wren, ram_addr, ram_byteena, ram_data}), 72'd0);
        sd_dv = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("t6_queue_empty", 72'(exp_q.size()), 72'd0);
        start_fill(8'h40, 3'd1);
        for (int i = 0; i < 8; i++) begin
            bp = 3'(1 + i);
            push(8'h40, bp, 16'(16'h7700 + i), i == 0, i == 7);
            send(16'(16'h7700 + i), 0);
        end
        step();
        exp_done++;
        chk("t6_crit_data", 72'(crit_data), 72'h7700);
        chk("t6_done_count", 72'(done_seen), 72'(exp_done));
        chk("t6_queue_empty_end", 72'(exp_q.size()), 72'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
